toggle_pulse_sender: RTL

- Source-domain transmitter for a toggle-based pulse crossing. It converts single-cycle request pulses in clk_a into toggle transitions on req_tgl for the destination domain.
- It waits for the destination's returned acknowledge toggle before sending the next transition, so no pulse is lost even when the destination clock is slow.
- Pulses that arrive while a transfer is in flight are counted and sent back-to-back, in order. Any excess beyond the queue depth is dropped and flagged.

---
 rtl/toggle_sync_pkg.sv | 20 ++
 rtl/bit_sync_ff.sv | 34 +++
 rtl/toggle_pulse_sender.sv | 133 +++++++++++++
 3 files changed

// File: rtl/toggle_sync_pkg.sv
// Shared types and helpers for the toggle-based pulse crossing (sender and receiver sides).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package toggle_sync_pkg;

  // Sender FSM: idle, or one toggle outstanding awaiting its acknowledge
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tx_state_e;

  // Default synchronizer depth for ack/req toggles crossing domains
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Bits needed to hold a pending count of 0..max_pending
  function automatic int pending_width(input int max_pending);
    return (max_pending < 1) ? 1 : $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/bit_sync_ff.sv
// Single-bit multi-flop synchronizer for level/toggle signals entering this clock domain.
// Latency: SYNC_STAGES clk edges from d_in to q_out.
// Backpressure: none; samples every cycle.
module bit_sync_ff
  import toggle_sync_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input into the bottom of the chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  // Synchronizer flops, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_pulse_sender.sv
// Source side of a toggle pulse crossing: queues request pulses and launches one req_tgl flip per acked transfer.
// Latency: pulse counted at edge N, launched at N+1; with loopback ack and 2 sync stages, 4 cycles per transfer.
// Backpressure: up to MAX_PENDING pulses queue behind the one in flight; extra pulses are dropped and flagged.
module toggle_pulse_sender
  import toggle_sync_pkg::*;
#(
  parameter int MAX_PENDING    = 4,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk_a,
  input  logic                                  rst_n,
  input  logic                                  pulse_in,
  input  logic                                  ack_tgl_in,
  output logic                                  req_tgl,
  output logic                                  busy,
  output logic                                  done_pulse,
  output logic                                  drop_pulse,
  output logic                                  overflow,
  output logic                                  timeout_err,
  output logic [pending_width(MAX_PENDING)-1:0] pending
);

  localparam int PW = pending_width(MAX_PENDING);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] MAX_P  = PW'(MAX_PENDING);
  localparam logic [PW-1:0] ONE_P  = PW'(1);
  localparam logic [TW-1:0] ONE_T  = TW'(1);
  // Counter saturates at the last allowed wait cycle; a zero timeout pins it at 0
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES < 1) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  tx_state_e     state_q, state_d;
  logic          req_tgl_q, req_tgl_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;

  logic ack_s;
  logic ack_match;
  logic launch;
  logic accept;

  // Bring the destination's acknowledge toggle into clk_a
  bit_sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk_a),
    .rst_n (rst_n),
    .d_in  (ack_tgl_in),
    .q_out (ack_s)
  );

  // The outstanding transfer is acknowledged once the synced ack level equals our request level
  assign ack_match = (ack_s == req_tgl_q);

  // FSM state register
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: launch whenever work is queued, return to idle on acknowledge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pending_q != '0) state_d = WAIT_ACK;
      WAIT_ACK: if (ack_match) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs and queue bookkeeping; a pulse in the launch cycle may take the freed slot
  always_comb begin
    launch     = (state_q == IDLE) && (pending_q != '0);
    accept     = pulse_in && ((pending_q < MAX_P) || launch);
    req_tgl_d  = req_tgl_q ^ launch;
    pending_d  = pending_q;
    if (accept && !launch) begin
      pending_d = pending_q + ONE_P;
    end else if (!accept && launch) begin
      pending_d = pending_q - ONE_P;
    end
    drop_d     = pulse_in && !accept;
    overflow_d = overflow_q | drop_d;
    done_d     = (state_q == WAIT_ACK) && ack_match;
    tcnt_d     = tcnt_q;
    timeout_d  = timeout_q;
    if (launch) begin
      tcnt_d = '0;
    end else if ((state_q == WAIT_ACK) && !ack_match) begin
      if (tcnt_q != T_LAST) tcnt_d = tcnt_q + ONE_T;
      if (TIMEOUT_EN && (tcnt_q == T_LAST)) timeout_d = 1'b1;
    end
  end

  // Datapath and status flops; sticky flags only clear on reset
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      req_tgl_q  <= 1'b0;
      pending_q  <= '0;
      tcnt_q     <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      req_tgl_q  <= req_tgl_d;
      pending_q  <= pending_d;
      tcnt_q     <= tcnt_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign req_tgl     = req_tgl_q;
  assign pending     = pending_q;
  assign done_pulse  = done_q;
  assign drop_pulse  = drop_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  // Decoded from flops only, so pulse_in has no combinational path to busy
  assign busy        = (state_q == WAIT_ACK) || (pending_q != '0);

endmodule
